pll_status_sequencer: RTL and testbench

- Parametrised multi-PLL status and reset sequencer sitting between the transceiver reset controller and NUM_PLLS transmit PLLs / master CGBs.
- Per PLL:
  - enforces a minimum powerdown pulse;
  - synchronises and debounces the raw lock;
  - holds the MCGB in reset until the lock has been stable for a set time;
  - reports a filtered lock and a sticky loss-of-lock flag.
- Replaces the single-PLL pass-through interconnect with independent per-channel state machines.

---
 rtl/pll_status_sequencer.sv | 141 ++++++++++++++
 tb/tb_pll_status_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_status_sequencer.sv
// Per-PLL powerdown, lock qualification and MCGB reset sequencer.
// Each channel runs an independent FSM on its synchronised lock input.
module pll_status_sequencer #(
    parameter int NUM_PLLS           = 1,
    parameter int LOCK_SYNC_STAGES   = 2,
    parameter int PD_HOLD_CYCLES     = 16,
    parameter int LOCK_FILTER_CYCLES = 64,
    parameter int MCGB_RST_DELAY     = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_PLLS-1:0] pll_locked,
    input  logic [NUM_PLLS-1:0] pll_powerdown_req,
    input  logic                lol_clear,
    output logic [NUM_PLLS-1:0] pll_powerdown,
    output logic [NUM_PLLS-1:0] mcgb_rst,
    output logic [NUM_PLLS-1:0] pll_locked_out,
    output logic                pll_locked_all,
    output logic [NUM_PLLS-1:0] lol_sticky
);

    localparam int CNT_MAX_A = (PD_HOLD_CYCLES > LOCK_FILTER_CYCLES) ? PD_HOLD_CYCLES : LOCK_FILTER_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > MCGB_RST_DELAY) ? CNT_MAX_A : MCGB_RST_DELAY;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PD_MAX   = CW'(PD_HOLD_CYCLES);
    localparam logic [CW-1:0] FLT_LAST = CW'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(MCGB_RST_DELAY - 1);

    typedef enum logic [1:0] {
        ST_PD,
        ST_WAIT_LOCK,
        ST_MCGB_REL,
        ST_LOCKED
    } state_e;

    for (genvar g = 0; g < NUM_PLLS; g++) begin : g_ch
        logic [LOCK_SYNC_STAGES-1:0] r_sync;
        state_e                      r_state;
        state_e                      w_state_nxt;
        logic [CW-1:0]               r_cnt;
        logic [CW-1:0]               w_cnt_nxt;
        logic                        w_lk_s;
        logic                        w_lol_set;
        logic                        r_pd;
        logic                        r_mcgb;
        logic                        r_lo;
        logic                        r_lol;

        assign w_lk_s = r_sync[LOCK_SYNC_STAGES-1];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[LOCK_SYNC_STAGES-2:0], pll_locked[g]};
            end
        end

        // A request outside PD pre-empts every lock-driven transition.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_lol_set   = 1'b0;
            if (r_state != ST_PD && pll_powerdown_req[g]) begin
                w_state_nxt = ST_PD;
                w_cnt_nxt   = '0;
            end else begin
                unique case (r_state)
                    ST_PD: begin
                        if (r_cnt == PD_MAX && !pll_powerdown_req[g]) begin
                            w_state_nxt = ST_WAIT_LOCK;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt != PD_MAX) begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (!w_lk_s) begin
                            w_cnt_nxt = '0;
                        end else if (r_cnt == FLT_LAST) begin
                            w_state_nxt = ST_MCGB_REL;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    ST_MCGB_REL: begin
                        if (!w_lk_s) begin
                            w_state_nxt = ST_WAIT_LOCK;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == DLY_LAST) begin
                            w_state_nxt = ST_LOCKED;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        w_cnt_nxt = '0;
                        if (!w_lk_s) begin
                            w_state_nxt = ST_WAIT_LOCK;
                            w_lol_set   = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_PD;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end

        // Outputs are decoded from the next state so they change with the transition edge.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= ST_PD;
                r_cnt   <= '0;
                r_pd    <= 1'b1;
                r_mcgb  <= 1'b1;
                r_lo    <= 1'b0;
                r_lol   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_pd    <= (w_state_nxt == ST_PD);
                r_mcgb  <= (w_state_nxt != ST_LOCKED);
                r_lo    <= (w_state_nxt == ST_LOCKED);
                r_lol   <= w_lol_set | (r_lol & ~lol_clear);
            end
        end

        assign pll_powerdown[g]  = r_pd;
        assign mcgb_rst[g]       = r_mcgb;
        assign pll_locked_out[g] = r_lo;
        assign lol_sticky[g]     = r_lol;
    end

    assign pll_locked_all = &pll_locked_out;

endmodule

// File: tb/tb_pll_status_sequencer.sv
// Scoreboard bench: expectations are queued against absolute cycle numbers
// when stimulus is applied and compared on the falling clock edge.
module tb_pll_status_sequencer;

    typedef enum int {S_PD, S_MCGB, S_LO, S_ALL, S_LOL} sig_e;

    typedef struct {
        int          cyc;
        int          d;
        sig_e        s;
        logic [15:0] v;
        string       tag;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       lol_clr = 1'b0;
    logic [1:0] locked_a = 2'b11;
    logic [1:0] req_a = 2'b00;
    logic [3:0] locked_b = 4'hF;
    logic [3:0] req_b = 4'h0;

    logic [1:0] pd_a, mcgb_a, lo_a, lol_a;
    logic       all_a;
    logic [3:0] pd_b, mcgb_b, lo_b, lol_b;
    logic       all_b;

    int        cyc = 0;
    int        n_checks = 0;
    int        n_errors = 0;
    sb_entry_t sb[$];
    sb_entry_t mon_e;

    pll_status_sequencer #(.NUM_PLLS(2)) u_dut_a (
        .clk(clk), .reset_n(rst_a), .pll_locked(locked_a), .pll_powerdown_req(req_a),
        .lol_clear(lol_clr), .pll_powerdown(pd_a), .mcgb_rst(mcgb_a),
        .pll_locked_out(lo_a), .pll_locked_all(all_a), .lol_sticky(lol_a)
    );

    pll_status_sequencer #(
        .NUM_PLLS(4), .PD_HOLD_CYCLES(4), .LOCK_FILTER_CYCLES(5), .MCGB_RST_DELAY(3)
    ) u_dut_b (
        .clk(clk), .reset_n(rst_b), .pll_locked(locked_b), .pll_powerdown_req(req_b),
        .lol_clear(lol_clr), .pll_powerdown(pd_b), .mcgb_rst(mcgb_b),
        .pll_locked_out(lo_b), .pll_locked_all(all_b), .lol_sticky(lol_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] obs(input int d, input sig_e s);
        if (d == 0) begin
            case (s)
                S_PD:    return {14'd0, pd_a};
                S_MCGB:  return {14'd0, mcgb_a};
                S_LO:    return {14'd0, lo_a};
                S_ALL:   return {15'd0, all_a};
                default: return {14'd0, lol_a};
            endcase
        end
        case (s)
            S_PD:    return {12'd0, pd_b};
            S_MCGB:  return {12'd0, mcgb_b};
            S_LO:    return {12'd0, lo_b};
            S_ALL:   return {15'd0, all_b};
            default: return {12'd0, lol_b};
        endcase
    endfunction

    task automatic expect_at(input int c, input int d, input sig_e s, input logic [15:0] v);
        sb_entry_t e;
        int        idx;
        e.cyc = c;
        e.d   = d;
        e.s   = s;
        e.v   = v;
        e.tag = $sformatf("%s_%s@%0d", (d == 0) ? "A" : "B", s.name(), c);
        idx = sb.size();
        while (idx > 0 && sb[idx-1].cyc > c) idx--;
        sb.insert(idx, e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check_eq(mon_e.tag, obs(mon_e.d, mon_e.s), mon_e.v);
        end
    end

    int r, l, b0, s, p, q, q2;

    initial begin
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        // Reset state for both instances
        expect_at(cyc + 1, 0, S_PD, 16'h3);   expect_at(cyc + 1, 0, S_MCGB, 16'h3);
        expect_at(cyc + 1, 0, S_LO, 16'h0);   expect_at(cyc + 1, 0, S_ALL, 16'h0);
        expect_at(cyc + 1, 0, S_LOL, 16'h0);
        expect_at(cyc + 1, 1, S_PD, 16'hF);   expect_at(cyc + 1, 1, S_MCGB, 16'hF);
        expect_at(cyc + 1, 1, S_LO, 16'h0);   expect_at(cyc + 1, 1, S_ALL, 16'h0);
        expect_at(cyc + 1, 1, S_LOL, 16'h0);

        // Power-up with lock tied high: PD for 17 cycles, then 64 + 8
        r = cyc + 2;
        wait_until(r);
        rst_a = 1'b1;
        expect_at(r + 16, 0, S_PD, 16'h3);   expect_at(r + 17, 0, S_PD, 16'h0);
        expect_at(r + 88, 0, S_MCGB, 16'h3); expect_at(r + 88, 0, S_LO, 16'h0);
        expect_at(r + 88, 0, S_ALL, 16'h0);
        expect_at(r + 89, 0, S_MCGB, 16'h0); expect_at(r + 89, 0, S_LO, 16'h3);
        expect_at(r + 89, 0, S_ALL, 16'h1);  expect_at(r + 89, 0, S_LOL, 16'h0);

        // Loss of lock on ch1 only, then clear the sticky flag
        l = r + 95;
        wait_until(l);
        locked_a = 2'b01;
        expect_at(l + 2, 0, S_LO, 16'h3);    expect_at(l + 2, 0, S_ALL, 16'h1);
        expect_at(l + 3, 0, S_LO, 16'h1);    expect_at(l + 3, 0, S_MCGB, 16'h2);
        expect_at(l + 3, 0, S_ALL, 16'h0);   expect_at(l + 3, 0, S_LOL, 16'h2);
        expect_at(l + 5, 0, S_LOL, 16'h2);   expect_at(l + 6, 0, S_LOL, 16'h0);
        wait_until(l + 5);
        lol_clr = 1'b1;
        wait_until(l + 6);
        lol_clr = 1'b0;

        // Lock bounce on ch1 in WAIT_LOCK: filter restarts after the glitch
        b0 = l + 8;
        wait_until(b0);
        locked_a = 2'b11;
        expect_at(b0 + 75, 0, S_LO, 16'h1);  expect_at(b0 + 75, 0, S_ALL, 16'h0);
        expect_at(b0 + 114, 0, S_LO, 16'h1);
        expect_at(b0 + 115, 0, S_LO, 16'h3); expect_at(b0 + 115, 0, S_MCGB, 16'h0);
        expect_at(b0 + 115, 0, S_ALL, 16'h1); expect_at(b0 + 115, 0, S_LOL, 16'h0);
        wait_until(b0 + 40);
        locked_a = 2'b01;
        wait_until(b0 + 41);
        locked_a = 2'b11;

        // Loss on ch0 with lol_clear on the same edge: set wins
        s = b0 + 120;
        wait_until(s);
        locked_a = 2'b10;
        expect_at(s + 3, 0, S_LO, 16'h2);    expect_at(s + 3, 0, S_LOL, 16'h1);
        expect_at(s + 4, 0, S_LOL, 16'h1);
        wait_until(s + 2);
        lol_clr = 1'b1;
        wait_until(s + 3);
        lol_clr = 1'b0;

        // Powerdown request on the WAIT_LOCK -> MCGB_REL qualification edge
        wait_until(s + 5);
        locked_a = 2'b11;
        expect_at(s + 70, 0, S_PD, 16'h0);   expect_at(s + 71, 0, S_PD, 16'h1);
        expect_at(s + 71, 0, S_MCGB, 16'h1); expect_at(s + 71, 0, S_LO, 16'h2);
        expect_at(s + 87, 0, S_PD, 16'h1);   expect_at(s + 88, 0, S_PD, 16'h0);
        expect_at(s + 159, 0, S_LO, 16'h2);  expect_at(s + 160, 0, S_LO, 16'h3);
        expect_at(s + 160, 0, S_LOL, 16'h1); expect_at(s + 163, 0, S_LOL, 16'h0);
        wait_until(s + 70);
        req_a = 2'b01;
        wait_until(s + 71);
        req_a = 2'b00;
        wait_until(s + 162);
        lol_clr = 1'b1;
        wait_until(s + 163);
        lol_clr = 1'b0;

        // Requested powerdown of ch1 from LOCKED, request held 3 cycles
        p = s + 170;
        wait_until(p);
        req_a = 2'b10;
        expect_at(p + 1, 0, S_PD, 16'h2);    expect_at(p + 1, 0, S_MCGB, 16'h2);
        expect_at(p + 1, 0, S_LO, 16'h1);    expect_at(p + 1, 0, S_ALL, 16'h0);
        expect_at(p + 1, 0, S_LOL, 16'h0);
        expect_at(p + 17, 0, S_PD, 16'h2);   expect_at(p + 18, 0, S_PD, 16'h0);
        expect_at(p + 18, 0, S_LOL, 16'h0);
        expect_at(p + 89, 0, S_LO, 16'h1);   expect_at(p + 90, 0, S_LO, 16'h3);
        expect_at(p + 90, 0, S_ALL, 16'h1);
        wait_until(p + 3);
        req_a = 2'b00;

        // Instance B: release, then asynchronous reset while in MCGB_REL
        q = p + 95;
        wait_until(q);
        rst_b = 1'b1;
        expect_at(q + 4, 1, S_PD, 16'hF);    expect_at(q + 5, 1, S_PD, 16'h0);
        expect_at(q + 10, 1, S_PD, 16'h0);   expect_at(q + 10, 1, S_MCGB, 16'hF);
        expect_at(q + 11, 1, S_PD, 16'hF);   expect_at(q + 11, 1, S_MCGB, 16'hF);
        expect_at(q + 11, 1, S_LO, 16'h0);   expect_at(q + 11, 1, S_ALL, 16'h0);
        expect_at(q + 11, 1, S_LOL, 16'h0);
        wait_until(q + 10);
        @(posedge clk);
        #1;
        rst_b = 1'b0;

        q2 = q + 14;
        wait_until(q2);
        rst_b = 1'b1;
        expect_at(q2 + 4, 1, S_PD, 16'hF);   expect_at(q2 + 5, 1, S_PD, 16'h0);
        expect_at(q2 + 10, 1, S_MCGB, 16'hF);
        expect_at(q2 + 12, 1, S_LO, 16'h0);  expect_at(q2 + 12, 1, S_MCGB, 16'hF);
        expect_at(q2 + 13, 1, S_LO, 16'hF);  expect_at(q2 + 13, 1, S_MCGB, 16'h0);
        expect_at(q2 + 13, 1, S_ALL, 16'h1); expect_at(q2 + 13, 1, S_LOL, 16'h0);

        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        check_eq("sb_drain", 16'(sb.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
